// File: rtl/usb_gpx_conditioner.sv
// Conditions the raw MAX3421E GPX pin: synchronizer, glitch filter, edge capture
// with maskable irq and a transition counter, behind a small Avalon-MM slave.
module usb_gpx_conditioner #(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        gpx_pin,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        gpx_clean
);

  localparam logic [15:0] CNT_MAX = 16'(FILTER_CYCLES - 1);

  logic        r_sync1, r_sync2;
  logic [15:0] r_cnt;
  logic        r_clean, r_clean_d;
  logic [1:0]  r_edge, r_mask;
  logic [15:0] r_count;
  logic [31:0] r_rdata;

  logic        w_rise, w_fall, w_wr;
  logic [1:0]  w_edge_clr;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  assign w_unused = ^writedata[31:2];

  assign w_rise     = r_clean & ~r_clean_d;
  assign w_fall     = ~r_clean & r_clean_d;
  assign w_wr       = chipselect & ~write_n;
  assign w_edge_clr = (w_wr && address == 2'd1) ? writedata[1:0] : 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_clean   <= 1'b0;
      r_clean_d <= 1'b0;
    end else begin
      r_sync1   <= gpx_pin;
      r_sync2   <= r_sync1;
      r_clean_d <= r_clean;
      // Any return to the current clean level restarts the qualification window.
      if (r_sync2 == r_clean) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_clean <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge  <= '0;
      r_mask  <= '0;
      r_count <= '0;
    end else begin
      // New edges are OR-ed in after the clear, so a coincident set wins.
      r_edge <= (r_edge & ~w_edge_clr) | {w_fall, w_rise};
      if (w_wr && address == 2'd2) r_mask <= writedata[1:0];
      if (w_wr && address == 2'd3)
        r_count <= {15'd0, w_rise | w_fall};
      else if (w_rise | w_fall)
        r_count <= r_count + 16'd1;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'd0: w_rd_mux[1:0]  = {r_sync2, r_clean};
      2'd1: w_rd_mux[1:0]  = r_edge;
      2'd2: w_rd_mux[1:0]  = r_mask;
      2'd3: w_rd_mux[15:0] = r_count;
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rdata <= '0;
    else          r_rdata <= w_rd_mux;
  end

  assign readdata  = r_rdata;
  assign gpx_clean = r_clean;
  assign irq       = |(r_edge & r_mask);

endmodule

// File: tb/tb_usb_gpx_conditioner.sv
// Directed bench for usb_gpx_conditioner at FILTER_CYCLES=4; expected values are
// worked out by hand from the pin-to-register timing.
module tb_usb_gpx_conditioner;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        gpx_pin = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic        gpx_clean;

  int n_tot = 0;
  int n_bad = 0;

  usb_gpx_conditioner #(.FILTER_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .gpx_pin(gpx_pin),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq),
    .gpx_clean(gpx_clean)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rdchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    tick();
    chk(tag, readdata, exp);
  endtask

  initial begin
    // reset defaults
    #3;
    chk("rst_rdata", readdata, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    chk("rst_clean", {31'd0, gpx_clean}, 0);
    ticks(2);
    reset_n = 1'b1;
    rdchk("rst_status", 2'd0, 0);
    rdchk("rst_edge", 2'd1, 0);
    rdchk("rst_mask", 2'd2, 0);
    rdchk("rst_count", 2'd3, 0);

    // valid rise: clean at k+5, EDGE/COUNT/irq at k+6
    wr(2'd2, 32'h1);
    rdchk("mask_rb", 2'd2, 1);
    gpx_pin = 1'b1;
    ticks(5);
    chk("rise_k4_clean", {31'd0, gpx_clean}, 0);
    tick();
    chk("rise_k5_clean", {31'd0, gpx_clean}, 1);
    tick();
    chk("rise_irq", {31'd0, irq}, 1);
    rdchk("rise_edge", 2'd1, 1);
    rdchk("rise_count", 2'd3, 1);
    rdchk("rise_status", 2'd0, 3);

    // W1C on rise bit drops irq right after the write edge
    wr(2'd1, 32'h1);
    chk("clr_irq", {31'd0, irq}, 0);
    rdchk("clr_edge", 2'd1, 0);

    // fall: bit1 captured but masked
    gpx_pin = 1'b0;
    ticks(7);
    chk("fall_clean", {31'd0, gpx_clean}, 0);
    chk("fall_irq_masked", {31'd0, irq}, 0);
    rdchk("fall_edge", 2'd1, 2);
    rdchk("fall_count", 2'd3, 2);
    rdchk("fall_status", 2'd0, 0);
    wr(2'd1, 32'h3);
    wr(2'd3, 32'h0);
    rdchk("clrall_edge", 2'd1, 0);
    rdchk("clrall_count", 2'd3, 0);

    // 3-cycle glitch is rejected
    gpx_pin = 1'b1;
    ticks(3);
    gpx_pin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch3_clean", {31'd0, gpx_clean}, 0);
    end
    rdchk("glitch3_edge", 2'd1, 0);
    rdchk("glitch3_count", 2'd3, 0);

    // 4-cycle pulse is the shortest accepted one
    gpx_pin = 1'b1;
    ticks(4);
    gpx_pin = 1'b0;
    ticks(14);
    chk("pulse4_clean", {31'd0, gpx_clean}, 0);
    chk("pulse4_irq", {31'd0, irq}, 1);
    rdchk("pulse4_edge", 2'd1, 3);
    rdchk("pulse4_count", 2'd3, 2);

    // clear coinciding with a new rise: set wins
    wr(2'd1, 32'h3);
    wr(2'd3, 32'h0);
    gpx_pin = 1'b1;
    ticks(6);
    wr(2'd1, 32'h1);
    rdchk("prio_edge", 2'd1, 1);

    // COUNT write coinciding with a transition leaves 1
    gpx_pin = 1'b0;
    ticks(6);
    wr(2'd3, 32'h5);
    rdchk("cntwr_count", 2'd3, 1);
    rdchk("cntwr_edge", 2'd1, 3);

    // wrap: preload near the top, then two real transitions
    force dut.r_count = 16'hFFFE;
    #1;
    release dut.r_count;
    rdchk("wrap_pre", 2'd3, 32'hFFFE);
    gpx_pin = 1'b1;
    ticks(8);
    rdchk("wrap_ffff", 2'd3, 32'hFFFF);
    gpx_pin = 1'b0;
    ticks(8);
    rdchk("wrap_zero", 2'd3, 0);

    // reset while the filter has counted to 2 with the pin high
    wr(2'd1, 32'h3);
    wr(2'd2, 32'h3);
    address = 2'd0;
    gpx_pin = 1'b1;
    ticks(4);
    chk("pre_rst_status", readdata, 2);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_rdata", readdata, 0);
    chk("mid_rst_irq", {31'd0, irq}, 0);
    chk("mid_rst_clean", {31'd0, gpx_clean}, 0);
    ticks(2);
    reset_n = 1'b1;
    address = 2'd1;
    ticks(5);
    chk("post_rst_k4_clean", {31'd0, gpx_clean}, 0);
    tick();
    chk("post_rst_k5_clean", {31'd0, gpx_clean}, 1);
    tick();
    rdchk("post_rst_edge", 2'd1, 1);
    rdchk("post_rst_mask", 2'd2, 0);
    rdchk("post_rst_count", 2'd3, 1);
    chk("post_rst_irq", {31'd0, irq}, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/usb_gpx_conditioner.md
# usb_gpx_conditioner

Conditions the raw GPX pin of the MAX3421E USB host controller before it reaches the SoC's 1-bit GPX parallel-input port. Two-flop synchronizer, digital glitch filter, rise/fall edge capture with maskable interrupt, and a transition counter. Exposed as a small Avalon-MM slave. Its `gpx_clean` output drives the GPX PIO `in_port` directly.

## Interface
- `FILTER_CYCLES`, default 4: consecutive cycles the synchronized level must differ from `gpx_clean` before `gpx_clean` follows it. Legal range 2..65535.
- `clk`, input, 1: system clock.
- `reset_n`, input, 1: asynchronous, active-low reset. Only clock and reset for the whole block.
- `gpx_pin`, input, 1: raw asynchronous GPX pin from the MAX3421E.
- `address`, input, 2: Avalon register select.
- `chipselect`, input, 1: Avalon select.
- `write_n`, input, 1: Avalon write strobe, active low.
- `writedata`, input, 32: Avalon write data.
- `readdata`, output, 32: registered read data.
- `irq`, output, 1: interrupt request, level, active high.
- `gpx_clean`, output, 1: filtered level; feeds the GPX PIO `in_port`.

## Operation
- **Synchronizer:** `sync1 <= gpx_pin`, then `sync2 <= sync1`.
- **Filter:** 16-bit counter `cnt`.
  - If `sync2 == gpx_clean`: `cnt <= 0`.
  - Else if `cnt == FILTER_CYCLES-1`: `gpx_clean <= sync2` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - A level that returns before the count completes is rejected, and the count restarts from 0.
- **Edge detect:** `clean_d <= gpx_clean`.
  - `rise = gpx_clean & ~clean_d`.
  - `fall = ~gpx_clean & clean_d`.
- **Register map** (all unused bits read 0):
  - Address 0, STATUS, read-only: bit0 `gpx_clean`, bit1 `sync2`. Writes are ignored.
  - Address 1, EDGE: bit0 rise captured, bit1 fall captured. Sticky. Writing 1 to a bit clears it. If a clear and a new edge on the same bit land in the same cycle, set wins.
  - Address 2, MASK: bits[1:0] read/write interrupt enables.
  - Address 3, COUNT: bits[15:0] count `gpx_clean` transitions, wrapping 0xFFFF→0x0000. Any write clears it. If a write and a transition land in the same cycle, the result is 1.
- **Bus timing:**
  - A write takes effect on the clock edge where `chipselect & ~write_n`.
  - `readdata` is updated every cycle with the addressed register, zero-extended, independent of `chipselect`.
  - Zero wait states. Read latency is 1 cycle.
- **Interrupt:** `irq = |(EDGE[1:0] & MASK[1:0])`, combinational from registers.
- **Reset values:** all registers clear to 0 (`sync1`, `sync2`, `cnt`, `gpx_clean`, `clean_d`, EDGE, MASK, COUNT, `readdata`), so `irq = 0`. If the pin is high when reset is released, a rising edge is filtered, captured and counted normally.

## Timing
- `gpx_pin` stable new value set up before clock edge k:
  - `sync1` updates at k, `sync2` at k+1.
  - `gpx_clean` updates at k+1+`FILTER_CYCLES` (k+5 at the default).
  - EDGE bit and COUNT update at k+2+`FILTER_CYCLES`. `irq` is valid in the same cycle.
- Shortest accepted pulse: `FILTER_CYCLES` cycles at `sync2`. Any pulse of `FILTER_CYCLES-1` cycles or fewer produces no change.
- Minimum output spacing: `gpx_clean` transitions are at least `FILTER_CYCLES` cycles apart.
- Reset asserted mid-filter or mid-pulse: all state clears immediately and no pending edge survives.
- Register write followed by a read of the same address: the read returns the new value one cycle after the write edge.

## Test plan
- **Reset default:** pin low, reset released → `gpx_clean=0`, `readdata=0`, `irq=0`. Read all four addresses → 0.
- **Valid rise:** `FILTER_CYCLES=4`, pin driven high before edge k → `gpx_clean=1` at k+5, EDGE=0x1 and COUNT=1 at k+6. With MASK=0x1, `irq=1`.
- **Glitch rejection:** pin high for 3 cycles then low → `gpx_clean` stays 0, EDGE=0, COUNT=0. Repeat with a 4-cycle pulse → one rise and one fall captured, COUNT=2.
- **Clear and priority:**
  - Write 0x1 to EDGE → bit0 clears and `irq` drops the next cycle.
  - A clear coinciding with a new rise → bit0 remains 1.
- **Counter behaviour:**
  - Preload by driving 65536 transitions → COUNT wraps to 0.
  - A write to COUNT coincident with a transition → COUNT=1.
- **Reset mid-operation:** assert `reset_n` low while `cnt=2` with the pin high → all registers 0. After release with the pin still high, `gpx_clean` rises 5 cycles later and EDGE=0x1.
